nv_ram_fifo_ctrl_61x64: RTL and testbench



---
 rtl/nv_ram_fifo_ctrl_61x64_pkg.sv | 23 ++
 rtl/nv_ram_fifo_ctrl_61x64_if.sv | 22 ++
 rtl/nv_ram_fifo_ctrl_61x64_skid3.sv | 59 +++++
 rtl/nv_ram_fifo_ctrl_61x64.sv | 104 ++++++++++
 tb/tb_nv_ram_fifo_ctrl_61x64.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nv_ram_fifo_ctrl_61x64_pkg.sv
// Shared sizing, types and pointer-wrap helper for the 61x64 RAM FIFO controller.
`timescale 1ns/1ps
package nv_ram_fifo_ctrl_61x64_pkg;

    localparam int DEPTH      = 61;
    localparam int WIDTH      = 64;
    localparam int SKID_DEPTH = 3;
    localparam int PTR_W      = 6;
    localparam int CNT_W      = 7;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [WIDTH-1:0] data_t;

    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
    localparam cnt_t RAM_FULL = cnt_t'(DEPTH);

    // Pointers run 0..DEPTH-1 and never visit the unused codes 61..63.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/nv_ram_fifo_ctrl_61x64_if.sv
// Push/pop valid-ready channels of the FIFO controller; slave is the FIFO side.
`timescale 1ns/1ps
interface nv_ram_fifo_ctrl_61x64_if;

    logic                                in_pvld;
    logic                                in_prdy;
    nv_ram_fifo_ctrl_61x64_pkg::data_t   in_pd;
    logic                                out_pvld;
    logic                                out_prdy;
    nv_ram_fifo_ctrl_61x64_pkg::data_t   out_pd;

    modport master (
        output in_pvld, in_pd, out_prdy,
        input  in_prdy, out_pvld, out_pd
    );

    modport slave (
        input  in_pvld, in_pd, out_prdy,
        output in_prdy, out_pvld, out_pd
    );

endinterface

// File: rtl/nv_ram_fifo_ctrl_61x64_skid3.sv
// nv_fifo_skid3: 3-entry circular skid buffer with push, pop, occupancy and head data.
`timescale 1ns/1ps
module nv_fifo_skid3
    import nv_ram_fifo_ctrl_61x64_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  data_t      push_data_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output data_t      head_o
);

    typedef logic [1:0] idx_t;

    data_t      mem_q [SKID_DEPTH];
    idx_t       wr_idx_q, wr_idx_d;
    idx_t       rd_idx_q, rd_idx_d;
    logic [1:0] cnt_q, cnt_d;

    function automatic idx_t idx_inc(input idx_t i);
        return (i == idx_t'(SKID_DEPTH - 1)) ? '0 : i + idx_t'(1);
    endfunction

    // NOTE: every variable is assigned on every path through this block; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        wr_idx_d = push_i ? idx_inc(wr_idx_q) : wr_idx_q;
        rd_idx_d = pop_i  ? idx_inc(rd_idx_q) : rd_idx_q;
        cnt_d    = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage is cleared too (only three words) so the head
            // reads zero out of reset and no stale word survives a reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_idx_q] <= push_data_i;
            end
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_idx_q];

endmodule

// File: rtl/nv_ram_fifo_ctrl_61x64.sv
// Valid/ready FIFO controller for an external 61x64 RAM with registered read path.
// Optional NV_RAM_FIFO_CTRL_BYPASS_EN: combinational skid bypass (latency 3 instead of 4).
`timescale 1ns/1ps
module nv_ram_fifo_ctrl_61x64
    import nv_ram_fifo_ctrl_61x64_pkg::*;
(
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rstn,
    nv_ram_fifo_ctrl_61x64_if.slave         fifo_if,
    output logic                            ram_we,
    output ptr_t                            ram_wa,
    output data_t                           ram_di,
    output logic                            ram_re,
    output ptr_t                            ram_ra,
    output logic                            ram_ore,
    input  data_t                           ram_dout,
    output cnt_t                            fifo_count,
    output logic                            fifo_idle
);

    logic       in_prdy, out_pvld, push, pop, issue;
    data_t      out_pd;
    cnt_t       ram_cnt_q, ram_cnt_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic       v1_q, v1_d, v2_q, v2_d;
    logic       skid_push, skid_pop;
    logic [1:0] skid_cnt;
    data_t      skid_head;
    logic [2:0] down_cnt;
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    logic       bypass;
`endif

    always_comb begin
        in_prdy = nvdla_core_rstn && (ram_cnt_q != RAM_FULL);
        push    = fifo_if.in_pvld && in_prdy;
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
        // A word leaving the RAM output register into an empty skid is offered directly.
        bypass    = v2_q && (skid_cnt == 2'd0);
        out_pvld  = nvdla_core_rstn && ((skid_cnt != 2'd0) || v2_q);
        out_pd    = bypass ? ram_dout : skid_head;
        skid_push = v2_q && !(bypass && fifo_if.out_prdy);
        skid_pop  = out_pvld && fifo_if.out_prdy && (skid_cnt != 2'd0);
`else
        out_pvld  = nvdla_core_rstn && (skid_cnt != 2'd0);
        out_pd    = skid_head;
        skid_push = v2_q;
        skid_pop  = out_pvld && fifo_if.out_prdy;
`endif
        pop = out_pvld && fifo_if.out_prdy;

        // Words past the RAM (in flight or held in skid) may never exceed skid capacity.
        down_cnt = 3'(v1_q) + 3'(v2_q) + 3'(skid_cnt);
        issue    = nvdla_core_rstn && (ram_cnt_q != '0)
                   && ((down_cnt - 3'(pop)) < 3'(SKID_DEPTH));

        ram_cnt_d = ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
        wr_ptr_d  = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        v1_d      = issue;
        v2_d      = v1_q;

        ram_we     = push;
        ram_wa     = wr_ptr_q;
        ram_di     = fifo_if.in_pd;
        ram_re     = issue;
        ram_ra     = rd_ptr_q;
        ram_ore    = nvdla_core_rstn && v1_q;
        fifo_count = ram_cnt_q + cnt_t'(v1_q) + cnt_t'(v2_q) + cnt_t'(skid_cnt);
        fifo_idle  = (fifo_count == '0);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            ram_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
        end else begin
            ram_cnt_q <= ram_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
        end
    end

    nv_fifo_skid3 u_skid (
        .clk         (nvdla_core_clk),
        .rst_n       (nvdla_core_rstn),
        .push_i      (skid_push),
        .push_data_i (ram_dout),
        .pop_i       (skid_pop),
        .count_o     (skid_cnt),
        .head_o      (skid_head)
    );

    assign fifo_if.in_prdy  = in_prdy;
    assign fifo_if.out_pvld = out_pvld;
    assign fifo_if.out_pd   = out_pd;

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_61x64.sv
// Self-checking bench for nv_ram_fifo_ctrl_61x64 with a behavioural two-port RAM beside it.
`timescale 1ns/1ps
module tb_nv_ram_fifo_ctrl_61x64;

`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        ram_we, ram_re, ram_ore;
    logic [5:0]  ram_wa, ram_ra;
    logic [63:0] ram_di, ram_dout;
    logic [6:0]  fifo_count;
    logic        fifo_idle;

    nv_ram_fifo_ctrl_61x64_if fifo_if ();

    nv_ram_fifo_ctrl_61x64 dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .fifo_if         (fifo_if),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_ore         (ram_ore),
        .ram_dout        (ram_dout),
        .fifo_count      (fifo_count),
        .fifo_idle       (fifo_idle)
    );

    // RAM with read-address register and output register.
    logic [63:0] mem [61];
    logic [5:0]  ram_addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_addr_q <= ram_ra;
        if (ram_ore) ram_dout <= mem[ram_addr_q];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] sb [$];
    bit          mon_en     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_pd    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Samples at the falling edge; records accepted pushes and checks every pop and stall.
    task automatic sample();
        @(negedge clk);
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", 64'(fifo_if.out_pvld), 64'd1);
                check("hold_data", fifo_if.out_pd, prev_pd);
            end
            if (fifo_if.in_pvld && fifo_if.in_prdy) sb.push_back(fifo_if.in_pd);
            if (fifo_if.out_pvld && fifo_if.out_prdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: popped %h with nothing outstanding", fifo_if.out_pd);
                end else begin
                    check("pop_data", fifo_if.out_pd, sb.pop_front());
                end
            end
            prev_stall = fifo_if.out_pvld && !fifo_if.out_prdy;
            prev_pd    = fifo_if.out_pd;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        fifo_if.in_pvld  = 1'b0;
        fifo_if.out_prdy = 1'b1;
        while ((sb.size() != 0 || !fifo_idle) && n < 300) begin
            sample();
            advance();
            n++;
        end
        sample();
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_idle"}, 64'(fifo_idle), 64'd1);
        check({name, "_out_pvld"}, 64'(fifo_if.out_pvld), 64'd0);
        advance();
    endtask

    typedef struct {
        logic        in_pvld;
        logic [63:0] in_pd;
        logic        out_prdy;
        logic        e_in_prdy;
        logic        e_we;
        logic        e_re;
        logic        e_ore;
        logic        e_out_pvld;
        logic [6:0]  e_count;
        logic [5:0]  e_addr;
        logic        chk_pd;
        logic [63:0] e_pd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] d0;
        int accepted, first_stall, bubbles, stalls, bad_addr, wr_wraps, rd_wraps;
        bit first_valid;
        logic [5:0] last_wa, last_ra;

        d0 = 64'hDEAD_BEEF_0000_0001;
        //          pvld  pd    prdy  rdy   we    re    ore   ovld  cnt    addr  chk   pd
        vecs[0] = '{1'b1, d0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 1'b0, 64'd0};
        vecs[1] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 6'd0, 1'b0, 64'd0};
        vecs[2] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd1, 6'd0, 1'b0, 64'd0};
        vecs[3] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BYP,  7'd1, 6'd0, BYP,  d0};
        vecs[4] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 6'd0, 1'b1, d0};
        vecs[5] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 1'b0, 64'd0};

        // Reset values, with inputs active to show the strobes are held off.
        rstn = 1'b0;
        fifo_if.in_pvld  = 1'b1;
        fifo_if.in_pd    = 64'h1234;
        fifo_if.out_prdy = 1'b1;
        advance();
        advance();
        sample();
        check("rst_in_prdy", 64'(fifo_if.in_prdy), 64'd0);
        check("rst_out_pvld", 64'(fifo_if.out_pvld), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_re", 64'(ram_re), 64'd0);
        check("rst_ram_ore", 64'(ram_ore), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_idle", 64'(fifo_idle), 64'd1);
        check("rst_out_pd", fifo_if.out_pd, 64'd0);
        advance();
        rstn = 1'b1;
        fifo_if.in_pvld  = 1'b0;
        fifo_if.out_prdy = 1'b0;
        sample();
        check("rel_in_prdy", 64'(fifo_if.in_prdy), 64'd1);
        advance();
        mon_en = 1'b1;

        // Single-push latency table.
        for (int i = 0; i < 6; i++) begin
            fifo_if.in_pvld  = vecs[i].in_pvld;
            fifo_if.in_pd    = vecs[i].in_pd;
            fifo_if.out_prdy = vecs[i].out_prdy;
            sample();
            check($sformatf("v%0d_in_prdy", i), 64'(fifo_if.in_prdy), 64'(vecs[i].e_in_prdy));
            check($sformatf("v%0d_ram_we", i), 64'(ram_we), 64'(vecs[i].e_we));
            check($sformatf("v%0d_ram_re", i), 64'(ram_re), 64'(vecs[i].e_re));
            check($sformatf("v%0d_ram_ore", i), 64'(ram_ore), 64'(vecs[i].e_ore));
            check($sformatf("v%0d_out_pvld", i), 64'(fifo_if.out_pvld), 64'(vecs[i].e_out_pvld));
            check($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_count));
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_ram_wa", i), 64'(ram_wa), 64'(vecs[i].e_addr));
                check($sformatf("v%0d_ram_di", i), ram_di, vecs[i].in_pd);
            end
            if (vecs[i].e_re) check($sformatf("v%0d_ram_ra", i), 64'(ram_ra), 64'(vecs[i].e_addr));
            if (vecs[i].chk_pd) check($sformatf("v%0d_out_pd", i), fifo_if.out_pd, vecs[i].e_pd);
            advance();
        end

        // Fill with the consumer stalled: 64 words fit, the 65th waits.
        accepted    = 0;
        first_stall = -1;
        fifo_if.out_prdy = 1'b0;
        for (int i = 0; i < 70; i++) begin
            fifo_if.in_pvld = 1'b1;
            fifo_if.in_pd   = 64'hF000_0000_0000_0000 + 64'(accepted);
            sample();
            if (fifo_if.in_prdy) accepted++;
            else if (first_stall < 0) first_stall = i;
            advance();
        end
        sample();
        check("fill_first_stall", 64'(first_stall), 64'd64);
        check("fill_accepted", 64'(accepted), 64'd64);
        check("fill_count", 64'(fifo_count), 64'd64);
        check("fill_in_prdy", 64'(fifo_if.in_prdy), 64'd0);
        check("fill_head", fifo_if.out_pd, 64'hF000_0000_0000_0000);
        advance();
        drain("fill");

        // Empty FIFO: push with out_prdy high must not produce a spurious valid.
        fifo_if.in_pvld  = 1'b1;
        fifo_if.in_pd    = 64'h5555_AAAA_0000_0007;
        fifo_if.out_prdy = 1'b1;
        sample();
        check("simul_t0_out_pvld", 64'(fifo_if.out_pvld), 64'd0);
        check("simul_t0_idle", 64'(fifo_idle), 64'd1);
        advance();
        fifo_if.in_pvld = 1'b0;
        sample();
        check("simul_t1_out_pvld", 64'(fifo_if.out_pvld), 64'd0);
        check("simul_t1_idle", 64'(fifo_idle), 64'd0);
        advance();
        sample();
        check("simul_t2_out_pvld", 64'(fifo_if.out_pvld), 64'd0);
        advance();
        sample();
        check("simul_t3_out_pvld", 64'(fifo_if.out_pvld), 64'(BYP));
        advance();
        drain("simul");

        // Continuous push and pop: no bubbles, pointers wrap 60->0.
        first_valid = 1'b0;
        bubbles = 0; stalls = 0; bad_addr = 0; wr_wraps = 0; rd_wraps = 0;
        last_wa = '0; last_ra = '0;
        for (int k = 0; k < 200; k++) begin
            fifo_if.in_pvld  = 1'b1;
            fifo_if.in_pd    = 64'h1000_0000_0000_0000 + 64'(k);
            fifo_if.out_prdy = 1'b1;
            sample();
            if (!fifo_if.in_prdy) stalls++;
            if (ram_we) begin
                if (ram_wa > 6'd60) bad_addr++;
                if (last_wa == 6'd60 && ram_wa == 6'd0) wr_wraps++;
                last_wa = ram_wa;
            end
            if (ram_re) begin
                if (ram_ra > 6'd60) bad_addr++;
                if (last_ra == 6'd60 && ram_ra == 6'd0) rd_wraps++;
                last_ra = ram_ra;
            end
            if (fifo_if.out_pvld) first_valid = 1'b1;
            else if (first_valid) bubbles++;
            advance();
        end
        check("stream_bubbles", 64'(bubbles), 64'd0);
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_addr_range", 64'(bad_addr), 64'd0);
        check("stream_wr_wrap", 64'(wr_wraps >= 3), 64'd1);
        check("stream_rd_wrap", 64'(rd_wraps >= 3), 64'd1);
        drain("stream");

        // Random consumer backpressure with a bursty producer.
        for (int k = 0; k < 400; k++) begin
            fifo_if.in_pvld  = ($urandom_range(0, 3) != 0);
            fifo_if.in_pd    = {$urandom(), $urandom()};
            fifo_if.out_prdy = $urandom_range(0, 1) != 0;
            sample();
            advance();
        end
        drain("random");

        // Reset with 20 entries held.
        fifo_if.out_prdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            fifo_if.in_pvld = 1'b1;
            fifo_if.in_pd   = 64'h2000_0000_0000_0000 + 64'(k);
            sample();
            advance();
        end
        fifo_if.in_pvld = 1'b0;
        sample();
        check("held20_count", 64'(fifo_count), 64'd20);
        rstn = 1'b0;
        advance();
        rstn = 1'b1;
        mon_en = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        sample();
        check("mid_rst_out_pvld", 64'(fifo_if.out_pvld), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_idle", 64'(fifo_idle), 64'd1);
        check("mid_rst_strobes", 64'({ram_we, ram_re, ram_ore}), 64'd0);
        advance();
        mon_en = 1'b1;
        fifo_if.in_pvld = 1'b1;
        fifo_if.in_pd   = 64'hCAFE_0000_0000_0042;
        sample();
        check("post_rst_ram_we", 64'(ram_we), 64'd1);
        check("post_rst_ram_wa", 64'(ram_wa), 64'd0);
        advance();
        fifo_if.in_pvld = 1'b0;
        sample();
        check("post_rst_ram_re", 64'(ram_re), 64'd1);
        check("post_rst_ram_ra", 64'(ram_ra), 64'd0);
        advance();
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
